// File: rtl/aud_dsp_cmd_arb_pkg.sv
// Shared types and command field layout for the audio DSP command arbiter.
// The FSM state enum, command field positions and parameter defaults live here.
package aud_dsp_cmd_arb_pkg;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int CMD_W_DEF       = 70;

  localparam int OP_LSB       = 0;
  localparam int OP_W         = 6;
  localparam int BUF_MODE_BIT = 6;
  localparam int BUF_SEL_BIT  = 7;
  localparam int QUANT_LSB    = 8;
  localparam int QUANT_W      = 6;
  localparam int OFF_W        = 8;
  localparam int IN_OFF_LSB   = 14;
  localparam int OUT_OFF_LSB  = 22;
  localparam int COEF_OFF_LSB = 30;
  localparam int PARAM0_LSB   = 38;
  localparam int PARAM0_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/aud_dsp_cmd_arb_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last
// time is chosen; a lone valid always wins.
module aud_dsp_rr_pick2 (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic last_grant,
  output logic any_valid,
  output logic winner
);

  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

endmodule

// File: rtl/aud_dsp_cmd_arb.sv
// Arbitrates host and sequencer commands onto the single DSP datapath.
// Define AUD_DSP_ARB_TIMEOUT_EN to build the WAIT-state abort counter.
import aud_dsp_cmd_arb_pkg::*;

module aud_dsp_cmd_arb #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CMD_W       = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             req1_ready,
  output logic             req1_done,
  output logic             req_err,
  output logic             dsp_start,
  output logic [CMD_W-1:0] dsp_cmd,
  input  logic             dsp_busy,
  output logic             grant_id,
  output logic             arb_busy
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             any_valid, winner;
  logic             rdy0, rdy1, fin, err;

`ifdef AUD_DSP_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  aud_dsp_rr_pick2 u_pick (
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .last_grant (grant_q),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    fin     = 1'b0;
    err     = 1'b0;
`ifdef AUD_DSP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (any_valid) begin
          grant_d = winner;
          cmd_d   = winner ? req1_cmd : req0_cmd;
          rdy0    = ~winner;
          rdy1    = winner;
          state_d = ST_ISSUE;
        end
      end
      (state_q == ST_ISSUE): state_d = ST_ARM;
      // ARM masks busy while the datapath reacts to the start pulse
      (state_q == ST_ARM): begin
        state_d = ST_WAIT;
`ifdef AUD_DSP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      (state_q == ST_WAIT): begin
        if (!dsp_busy) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef AUD_DSP_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          fin     = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b1;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
    end
  end

`ifdef AUD_DSP_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign req_err = err;
`else
  assign req_err = err & 1'b0;
`endif

  // ready is combinational in IDLE, so hold it low while reset is asserted
  assign req0_ready = rst_n & rdy0;
  assign req1_ready = rst_n & rdy1;
  assign req0_done  = fin & ~grant_q;
  assign req1_done  = fin & grant_q;
  assign dsp_start  = (state_q == ST_ISSUE);
  assign dsp_cmd    = cmd_q;
  assign grant_id   = grant_q;
  assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aud_dsp_cmd_arb.sv
// Self-checking bench for aud_dsp_cmd_arb: per-cycle transaction model plus
// directed scenarios with hand-computed latencies.
module tb_aud_dsp_cmd_arb;

  localparam int TO = 16;
  localparam int CW = 70;
`ifdef AUD_DSP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [CW-1:0] req0_cmd = '0, req1_cmd = '0;
  logic          req0_ready, req1_ready, req0_done, req1_done;
  logic          req_err, dsp_start, grant_id, arb_busy;
  logic [CW-1:0] dsp_cmd;
  logic          dsp_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_len = 0;
  int cyc = 0;

  int m_phase = 0;
  bit m_last = 1'b1;
  logic [CW-1:0] m_cmd = '0;
  int m_wcnt = 0;

  int acc_cyc[$];
  bit acc_id[$];
  int start_cyc[$];
  int done_cyc[$];
  bit done_id[$];
  bit done_err[$];

  always #5 clk = ~clk;

  aud_dsp_cmd_arb #(.TIMEOUT_CYC(TO), .CMD_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_cmd   (req0_cmd),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_cmd   (req1_cmd),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req_err    (req_err),
    .dsp_start  (dsp_start),
    .dsp_cmd    (dsp_cmd),
    .dsp_busy   (dsp_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  // DSP stand-in: busy for busy_len cycles after each start pulse
  initial begin
    int bcnt = 0;
    bit st;
    forever begin
      @(negedge clk);
      st = dsp_start;
      @(posedge clk);
      #1;
      if (!rst_n) bcnt = 0;
      else if (st) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      dsp_busy = (bcnt > 0);
    end
  end

  // Transaction-level model and per-cycle comparison
  always @(negedge clk) begin
    logic [7:0] act_v, exp_v;
    bit win, fin, ferr;
    cyc++;
    act_v = {req0_ready, req1_ready, dsp_start, req0_done,
             req1_done, req_err, arb_busy, grant_id};
    if (!rst_n) begin
      chk("reset_outputs", act_v, 8'b0000_0001);
      chk("reset_dsp_cmd", dsp_cmd, '0);
      m_phase = 0;
      m_last  = 1'b1;
      m_cmd   = '0;
      m_wcnt  = 0;
    end else begin
      exp_v = '0;
      win = 1'b0;
      fin = 1'b0;
      ferr = 1'b0;
      if (m_phase == 0 && (req0_valid || req1_valid)) begin
        win = (req0_valid && req1_valid) ? !m_last : req1_valid;
        if (win) exp_v[6] = 1'b1;
        else     exp_v[7] = 1'b1;
      end
      if (m_phase == 1) exp_v[5] = 1'b1;
      if (m_phase >= 3) begin
        if (!dsp_busy) fin = 1'b1;
        else if (TO_EN && m_wcnt == TO - 1) begin
          fin = 1'b1;
          ferr = 1'b1;
        end
      end
      if (fin) begin
        if (m_last) exp_v[3] = 1'b1;
        else        exp_v[4] = 1'b1;
        exp_v[2] = ferr;
      end
      exp_v[1] = (m_phase != 0);
      exp_v[0] = m_last;
      chk("outputs", act_v, exp_v);
      chk("dsp_cmd", dsp_cmd, m_cmd);
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(req1_ready);
      end
      if (dsp_start) start_cyc.push_back(cyc);
      if (req0_done || req1_done) begin
        done_cyc.push_back(cyc);
        done_id.push_back(req1_done);
        done_err.push_back(req_err);
      end
      if (m_phase == 0) begin
        if (req0_valid || req1_valid) begin
          m_phase = 1;
          m_last  = win;
          m_cmd   = win ? req1_cmd : req0_cmd;
        end
      end else if (m_phase < 3) begin
        m_phase++;
        m_wcnt = 0;
      end else if (fin) begin
        m_phase = 0;
      end else begin
        m_wcnt++;
      end
    end
  end

  task automatic send(input bit id, input logic [CW-1:0] c);
    int t = 0;
    bit got = 0;
    if (id) begin req1_cmd = c; req1_valid = 1'b1; end
    else    begin req0_cmd = c; req0_valid = 1'b1; end
    while (!got && t < 300) begin
      @(negedge clk);
      t++;
      got = id ? req1_ready : req0_ready;
    end
    if (!got) bound_fail(id ? "ready1_wait" : "ready0_wait");
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    bit ok = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      t++;
      ok = !arb_busy && !dsp_busy;
    end
    if (!ok) bound_fail("idle_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy_len = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant_id, 1);
    chk("rst_arb_busy", arb_busy, 0);
    rst_n = 1'b1;

    busy_len = 10;
    send(0, 70'h2_0123_4567_89AB_CDEF);
    wait_idle();
    chk("single_acc_id", acc_id[$], 0);
    chk("single_start_lat", start_cyc[$] - acc_cyc[$], 1);
    chk("single_done_lat", done_cyc[$] - acc_cyc[$], 12);
    chk("single_err", done_err[$], 0);

    do_reset();
    busy_len = 2;
    fork
      begin
        send(0, 70'h1_1111_0000_AAAA_0001);
        send(0, 70'h1_1111_0000_AAAA_0002);
      end
      begin
        send(1, 70'h3_2222_0000_BBBB_0001);
        send(1, 70'h3_2222_0000_BBBB_0002);
      end
    join
    wait_idle();
    n = acc_id.size();
    for (int k = 0; k < 4; k++) chk("rr_order", acc_id[n - 4 + k], k % 2);
    chk("rr_last_cmd", dsp_cmd, 70'h3_2222_0000_BBBB_0002);

    busy_len = 0;
    send(0, 70'h0_0000_1234_0000_0042);
    send(0, 70'h0_0000_5678_0000_0043);
    wait_idle();
    n = acc_cyc.size();
    nd = done_cyc.size();
    chk("min_period_done", done_cyc[nd - 2] - acc_cyc[n - 2], 3);
    chk("min_period_next", acc_cyc[n - 1] - acc_cyc[n - 2], 4);
    chk("min_period_err", done_err[nd - 2], 0);

    busy_len = 40;
    send(0, 70'h0_F00D_0000_0000_0099);
    wait_idle();
    chk("stuck_done_lat", done_cyc[$] - acc_cyc[$], TO_EN ? 18 : 42);
    chk("stuck_err", done_err[$], TO_EN);

    busy_len = 8;
    send(0, 70'h0_0000_0000_0000_0A0A);
    repeat (2) @(posedge clk);
    #1;
    send(1, 70'h0_0000_0000_0000_0B0B);
    wait_idle();
    nd = done_cyc.size();
    chk("holdoff_id", acc_id[$], 1);
    chk("holdoff_lat", acc_cyc[$] - done_cyc[nd - 2], 1);

    busy_len = 40;
    send(0, 70'h0_0000_0000_0000_0C0C);
    repeat (4) @(posedge clk);
    #1;
    nd = done_cyc.size();
    rst_n = 1'b0;
    #1;
    chk("async_arb_busy", arb_busy, 0);
    chk("async_grant", grant_id, 1);
    chk("async_cmd", dsp_cmd, '0);
    chk("async_pulses", {req0_done, req1_done, req_err, dsp_start}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_len = 0;
    send(1, 70'h0_0000_0000_0000_0D0D);
    wait_idle();
    chk("post_rst_dones", done_cyc.size(), nd + 1);
    chk("post_rst_acc_id", acc_id[$], 1);
    chk("post_rst_done_id", done_id[$], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aud_dsp_cmd_arb.md
AUD_DSP_CMD_ARB -- requirements
Module: aud_dsp_cmd_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096: maximum cycles a granted command may keep the DSP busy before it is aborted.
REQ-002 Parameter CMD_W, default 70: packed command width, using the shared op/buf/offset/param0 field layout.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0 (host register path) / requester 1 (command sequencer) has a command pending.
REQ-006 req0_cmd / req1_cmd  input  CMD_W each  command word; held stable while the matching valid is high.
REQ-007 req0_ready / req1_ready  output  1 each  one-cycle accept pulse.
REQ-008 req0_done / req1_done  output  1 each  one-cycle completion pulse to the owner.
REQ-009 req_err  output  1  qualifies a done pulse; 1 = aborted by timeout.
REQ-010 dsp_start  output  1  one-cycle start pulse to the DSP datapath.
REQ-011 dsp_cmd  output  CMD_W  registered command, stable from start until done.
REQ-012 dsp_busy  input  1  DSP datapath busy.
REQ-013 grant_id  output  1  owner of the current or last command.
REQ-014 arb_busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, ARM, WAIT.
REQ-016 IDLE: if any valid is high, the FSM SHALL pick a winner, pulse its ready, latch its cmd into dsp_cmd, set grant_id, and go to ISSUE on the next cycle.
REQ-017 Arbitration SHALL be round-robin: when both valids are high, the requester not equal to last grant_id wins; a single valid always wins.
REQ-018 ISSUE: dsp_start SHALL be 1 for exactly this one cycle, then the FSM goes to ARM.
REQ-019 ARM: dsp_busy SHALL be ignored for this one cycle to cover start-to-busy latency, then the FSM goes to WAIT.
REQ-020 WAIT, dsp_busy low: the FSM SHALL pulse done[grant_id] with req_err=0 and return to IDLE.
REQ-021 WAIT timeout counter: clears on entry to WAIT and increments each WAIT cycle while busy is high.
REQ-022 WAIT timeout: when the counter equals TIMEOUT_CYC-1 with busy still high, the FSM SHALL pulse done[grant_id] with req_err=1 and return to IDLE.
REQ-023 Minimum command period SHALL be 4 cycles (accept, ISSUE, ARM, WAIT with busy already low).
REQ-024 A valid asserted during ISSUE/ARM/WAIT SHALL be held off (ready=0) and considered in the next IDLE cycle.
REQ-025 Back-to-back requests SHALL be accepted in the same cycle a done pulse returns the FSM to IDLE (accept occurs in the IDLE cycle that follows).
REQ-026 A requester dropping valid before ready is a protocol violation; the block does not need to handle it.
REQ-027 At most one ready, one done and one dsp_start pulse SHALL occur in any cycle.

Reset
REQ-028 On rst_n low: FSM=IDLE; dsp_start, ready*, done*, req_err, arb_busy = 0; dsp_cmd=0; grant_id=1 (so requester 0 wins first tie); timeout counter=0.
REQ-029 Reset mid-command SHALL abandon the command without a done pulse; the DSP datapath is reset by the same rst_n.

Configuration
REQ-030 With macro AUD_DSP_ARB_TIMEOUT_EN defined, the timeout counter and req_err behaviour of REQ-021/REQ-022 are present.
REQ-031 Without AUD_DSP_ARB_TIMEOUT_EN, no counter is built, req_err is tied to 0, and WAIT exits only on dsp_busy low.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the command field offsets/widths (op[5:0], buf_sel_mode[6], buf_sel[7], quant[13:8], in_off[21:14], out_off[29:22], coef_off[37:30], param0[69:38]) and the TIMEOUT_CYC default.
REQ-033 The round-robin pick SHALL be a sub-module, aud_dsp_rr_pick2: inputs two valids and last grant; output the winner.

Verification
REQ-034 req0 only, busy high 10 cycles after start: accept on cycle 0, dsp_start on cycle 1, done0 pulses the cycle after busy falls, req_err=0.
REQ-035 req0 and req1 valid together from reset: grant order 0,1,0,1 over four commands; dsp_cmd matches the winner's cmd each time.
REQ-036 busy never asserts: done pulses at cycle 3 (accept, ISSUE, ARM, WAIT) with req_err=0; the next accept follows in the IDLE cycle.
REQ-037 TIMEOUT_CYC=16 with AUD_DSP_ARB_TIMEOUT_EN, busy stuck high: done with req_err=1 after 16 WAIT cycles; without the macro, no done until busy drops.
REQ-038 rst_n pulsed low during WAIT: all outputs reach reset values asynchronously, no done pulse, and the next req1 is accepted normally.
REQ-039 req1 asserted during WAIT of req0: req1_ready stays 0 until done0, then is accepted in the following IDLE cycle.
